// File: rtl/fpu32_pkg.sv
// Shared binary32 field widths, special encodings and the unpacked operand view
// used by the adder/subtractor datapath.
package fpu32_pkg;

  localparam int          EXP_W    = 8;
  localparam int          FRAC_W   = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fpu32_lzc.sv
// 27-bit leading-zero counter used to renormalise the difference after an
// effective subtraction; an all-zero input reports 27.
module fpu32_lzc (
  input  logic [26:0] i_data,
  output logic [4:0]  o_count
);

  logic [26:0] lead;

  // One-hot marker on the most significant set bit.
  genvar gi;
  generate
    for (gi = 0; gi < 27; gi++) begin : g_lead
      if (gi == 26) begin : g_top
        assign lead[gi] = i_data[gi];
      end else begin : g_rest
        assign lead[gi] = i_data[gi] & ~(|i_data[26:gi+1]);
      end
    end
  endgenerate

  always_comb begin
    o_count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (lead[i]) o_count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fpu32_add_sub.sv
// Binary32 add/subtract with flush-to-zero and a single result register.
// Define FPU32_ADD_SUB_RNE_EN for round-to-nearest-even; otherwise truncation.
module fpu32_add_sub
  import fpu32_pkg::*;
#(
  parameter int SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alu_op,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic [SIZE_DATA-1:0] o_result
);

  fp32_t       op_a, op_b;
  logic        sign_a, sign_b;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [23:0] man_a, man_b;

  assign op_a   = i_data_a;
  assign op_b   = i_data_b;
  assign sign_a = op_a.sign;
  assign sign_b = op_b.sign ^ i_alu_op;
  assign zero_a = (op_a.exp == '0);
  assign zero_b = (op_b.exp == '0);
  assign inf_a  = (op_a.exp == EXP_MAX) && (op_a.frac == '0);
  assign inf_b  = (op_b.exp == EXP_MAX) && (op_b.frac == '0);
  assign nan_a  = (op_a.exp == EXP_MAX) && (op_a.frac != '0);
  assign nan_b  = (op_b.exp == EXP_MAX) && (op_b.frac != '0);
  assign man_a  = {~zero_a, op_a.frac};
  assign man_b  = {~zero_b, op_b.frac};

  logic        special;
  logic [31:0] special_result;

  always_comb begin
    special        = 1'b1;
    special_result = '0;
    if (nan_a || nan_b) begin
      special_result = QNAN;
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      special_result = QNAN;
    end else if (inf_a) begin
      special_result = POS_INF | {sign_a, 31'd0};
    end else if (inf_b) begin
      special_result = POS_INF | {sign_b, 31'd0};
    end else if (zero_a && zero_b) begin
      special_result = {sign_a & sign_b, 31'd0};
    end else if (zero_a) begin
      special_result = {sign_b, op_b.exp, op_b.frac};
    end else if (zero_b) begin
      special_result = {sign_a, op_a.exp, op_a.frac};
    end else begin
      special = 1'b0;
    end
  end

  // Order operands by magnitude so the subtraction never goes negative.
  logic        a_larger, eff_sub, sign_l;
  logic [7:0]  exp_l, exp_s, exp_diff;
  logic [23:0] man_l, man_s;

  assign a_larger = {op_a.exp, man_a} >= {op_b.exp, man_b};
  assign eff_sub  = sign_a ^ sign_b;
  assign sign_l   = a_larger ? sign_a : sign_b;
  assign exp_l    = a_larger ? op_a.exp : op_b.exp;
  assign exp_s    = a_larger ? op_b.exp : op_a.exp;
  assign man_l    = a_larger ? man_a : man_b;
  assign man_s    = a_larger ? man_b : man_a;
  assign exp_diff = exp_l - exp_s;

  logic [26:0] big, ext_s, lost_mask, shifted_s, aligned_s;

  assign big   = {man_l, 3'b000};
  assign ext_s = {man_s, 3'b000};

  always_comb begin
    lost_mask = '0;
    shifted_s = '0;
    if (exp_diff >= 8'd26) begin
      aligned_s = 27'd1;
    end else begin
      lost_mask = (27'd1 << exp_diff) - 27'd1;
      shifted_s = ext_s >> exp_diff;
      aligned_s = {shifted_s[26:1], shifted_s[0] | (|(ext_s & lost_mask))};
    end
  end

  logic [27:0] sum;
  logic [26:0] diff_mag;
  logic [4:0]  lz_count;

  assign sum      = {1'b0, big} + {1'b0, aligned_s};
  assign diff_mag = big - aligned_s;

  fpu32_lzc u_lzc (
    .i_data  (diff_mag),
    .o_count (lz_count)
  );

  logic [26:0]       norm_mant;
  logic signed [9:0] norm_exp;
  logic              exact_zero, flush;

  always_comb begin
    norm_mant  = '0;
    norm_exp   = '0;
    exact_zero = 1'b0;
    flush      = 1'b0;
    if (!eff_sub) begin
      if (sum[27]) begin
        norm_mant = {sum[27:2], sum[1] | sum[0]};
        norm_exp  = $signed({2'b00, exp_l}) + 10'sd1;
      end else begin
        norm_mant = sum[26:0];
        norm_exp  = $signed({2'b00, exp_l});
      end
    end else begin
      exact_zero = (diff_mag == '0);
      norm_mant  = diff_mag << lz_count;
      norm_exp   = $signed({2'b00, exp_l}) - $signed({5'b00000, lz_count});
      flush      = (norm_exp <= 10'sd0);
    end
  end

  logic              round_up;
  logic [24:0]       rounded;
  logic signed [9:0] final_exp;
  logic [22:0]       final_frac;

`ifdef FPU32_ADD_SUB_RNE_EN
  assign round_up = norm_mant[2] & (norm_mant[1] | norm_mant[0] | norm_mant[3]);
`else
  logic unused_grs;
  assign round_up   = 1'b0;
  assign unused_grs = ^norm_mant[2:0];
`endif

  assign rounded = {1'b0, norm_mant[26:3]} + {24'd0, round_up};

  always_comb begin
    if (rounded[24]) begin
      final_exp  = norm_exp + 10'sd1;
      final_frac = rounded[23:1];
    end else begin
      final_exp  = norm_exp;
      final_frac = rounded[22:0];
    end
  end

  logic [31:0] result_next, result_reg;

  always_comb begin
    if (special) begin
      result_next = special_result;
    end else if (exact_zero) begin
      result_next = '0;
    end else if (flush) begin
      result_next = {sign_l, 31'd0};
    end else if (final_exp >= 10'sd255) begin
      result_next = POS_INF | {sign_l, 31'd0};
    end else begin
      result_next = {sign_l, final_exp[7:0], final_frac};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign o_result = result_reg;

endmodule

// File: tb/tb_fpu32_add_sub.sv
// Scoreboard bench for fpu32_add_sub: expectations are queued at drive time and
// compared one edge later; integer-valued random ops use an independent int-to-float model.
module tb_fpu32_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_op = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  fpu32_add_sub #(.SIZE_DATA(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_alu_op (alu_op),
    .i_data_a (data_a),
    .i_data_b (data_b),
    .o_result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("%-10s got %08h ok", tag, got);
    end else begin
      $display("FAIL %s: got %08h, expected %08h", tag, got, want);
    end
  endtask

  // Exact for |v| < 2^24; zero maps to +0.
  function automatic logic [31:0] int_to_fp(input int v);
    logic [31:0] m;
    logic        s;
    int          p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic rst_val, input logic [31:0] want, input string tag);
    @(negedge clk);
    data_a = a;
    data_b = b;
    alu_op = op;
    rst_n  = rst_val;
    exp_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), result, exp_q.pop_front());
      end
    end
  end

  initial begin
    int x, y;
    logic op;

    issue(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h00000000, "rst0");
    issue(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h00000000, "rst1");

    issue(32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, "add_1_2");
    issue(32'h40400000, 32'h3F800000, 1'b1, 1'b1, 32'h40000000, "sub_3_1");
    issue(32'h3F800000, 32'h3F800000, 1'b1, 1'b1, 32'h00000000, "sub_eq");
    issue(32'h3F800000, 32'h40000000, 1'b1, 1'b1, 32'hBF800000, "sub_neg");
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F800000, "ovf_inf");
    issue(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, "inf_inf");
    issue(32'h7FC00001, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000, "nan_a");
    issue(32'h3F800000, 32'h7FC00000, 1'b1, 1'b1, 32'h7FC00000, "nan_b");
    issue(32'hFF800000, 32'h3F800000, 1'b0, 1'b1, 32'hFF800000, "ninf_fin");
`ifdef FPU32_ADD_SUB_RNE_EN
    issue(32'h4B800000, 32'h3FC00000, 1'b0, 1'b1, 32'h4B800001, "rnd_up");
    issue(32'h4B800001, 32'h3F800000, 1'b0, 1'b1, 32'h4B800002, "rnd_odd");
`else
    issue(32'h4B800000, 32'h3FC00000, 1'b0, 1'b1, 32'h4B800000, "rnd_up");
    issue(32'h4B800001, 32'h3F800000, 1'b0, 1'b1, 32'h4B800001, "rnd_odd");
`endif
    issue(32'h4B800000, 32'h3F800000, 1'b0, 1'b1, 32'h4B800000, "rnd_tie");
    issue(32'h3F800000, 32'h30800000, 1'b0, 1'b1, 32'h3F800000, "far_shift");
    issue(32'h00400000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, "ftz_sub");
    issue(32'h00800000, 32'h00400001, 1'b1, 1'b1, 32'h00800000, "ftz_b");
    issue(32'h00C00000, 32'h00800001, 1'b1, 1'b1, 32'h00000000, "ftz_res");
    issue(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, "nz_nz");
    issue(32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h00000000, "nz_sub_nz");
    issue(32'h00000000, 32'h40400000, 1'b1, 1'b1, 32'hC0400000, "z_sub_b");

    for (int i = 0; i < 12; i++) begin
      x  = int'($urandom_range(2000)) - 1000;
      y  = int'($urandom_range(2000)) - 1000;
      op = 1'($urandom_range(1));
      issue(int_to_fp(x), int_to_fp(y), op, 1'b1, int_to_fp(op ? x - y : x + y),
            $sformatf("rnd%0d", i));
    end

    issue(32'h40400000, 32'h40400000, 1'b0, 1'b0, 32'h00000000, "rst_mid");
    issue(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000, "post_rst");
    issue(32'h40400000, 32'h3F800000, 1'b0, 1'b1, 32'h40800000, "hold");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
